// File: rtl/seg7_defs.sv
// Shared constants and elaboration helpers for the 7-segment display scanner
// and the generic prescaler it uses.
package seg7_defs;

   localparam logic [7:0] AN_OFF = 8'hFF;
   localparam logic       DP_OFF = 1'b1;

   // Bits needed to hold the values 0..v-1.
   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r++;
         x = x >> 1;
      end
      return r;
   endfunction

   function automatic bit params_ok(input int nd, input int sd, input int dead,
                                    input int bd);
      return (nd >= 2) && (nd <= 8) && (dead >= 1) && (sd >= dead + 2) && (bd >= 1);
   endfunction

endpackage

// File: rtl/tick_div.sv
// Generic modulo-N prescaler: counts 0..N-1, wraps, and flags the terminal count.
module tick_div
   import seg7_defs::*;
#(
   parameter int N = 8,
   parameter int W = clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   output logic [W-1:0] cnt,
   output logic         tc
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      tc    = (cnt_q == W'(N - 1));
      cnt_d = tc ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed common-anode 7-segment scanner with blanking, blinking,
// decimal points and dead time between digit slots.
module seg7_scan
   import seg7_defs::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter int SCAN_DIV   = 50000,
   parameter int DEAD       = 4,
   parameter int BLINK_DIV  = 250
) (
   input  logic                    iCLK,
   input  logic                    iRST_N,
   input  logic [4*NUM_DIGITS-1:0] iDIGITS,
   input  logic [NUM_DIGITS-1:0]   iBLANK,
   input  logic [NUM_DIGITS-1:0]   iBLINK,
   input  logic [NUM_DIGITS-1:0]   iDP,
   output logic [3:0]              oDIG,
   output logic [NUM_DIGITS-1:0]   oAN,
   output logic                    oDP,
   output logic                    oFRAME
);

   localparam int IW = clog2(NUM_DIGITS);
   localparam int PW = clog2(SCAN_DIV);
   localparam int FW = clog2(BLINK_DIV + 1);
   localparam logic [PW-1:0]         DEAD_M1 = PW'(DEAD - 1);
   localparam logic [NUM_DIGITS-1:0] AN_ALL  = AN_OFF[NUM_DIGITS-1:0];

   if (!params_ok(NUM_DIGITS, SCAN_DIV, DEAD, BLINK_DIV)) begin : g_bad_params
      $error("seg7_scan: illegal parameter combination");
   end

   logic [PW-1:0] pre;
   logic          tick;

   tick_div #(.N(SCAN_DIV), .W(PW)) u_pre (
      .clk   (iCLK),
      .rst_n (iRST_N),
      .cnt   (pre),
      .tc    (tick)
   );

   logic [IW-1:0]         idx_q, idx_d;
   logic [FW-1:0]         fc_q, fc_d;
   logic                  bph_q, bph_d;
   logic                  init_q, init_d;
   logic                  dark_q, dark_d;
   logic [3:0]            dig_q, dig_d;
   logic                  dp_q, dp_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic                  frame_q, frame_d;
   logic                  wrap;
   logic                  load;

   always_comb begin
      wrap   = tick && (idx_q == IW'(NUM_DIGITS - 1));
      idx_d  = idx_q;
      fc_d   = fc_q;
      bph_d  = bph_q;
      init_d = 1'b0;
      if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;
      if (wrap) begin
         if (fc_q == FW'(BLINK_DIV - 1)) begin
            fc_d  = '0;
            bph_d = ~bph_q;
         end else begin
            fc_d = fc_q + 1'b1;
         end
      end

      // Inputs are captured only when a slot starts (or on the first edge
      // after reset), so the decoder sees one stable code per slot.
      load   = tick || init_q;
      dark_d = dark_q;
      dig_d  = dig_q;
      dp_d   = dp_q;
      if (load) begin
         dark_d = iBLANK[idx_d] || (iBLINK[idx_d] && !bph_d);
         dig_d  = iDIGITS[4*idx_d +: 4];
         dp_d   = dark_d ? DP_OFF : ~iDP[idx_d];
      end

      // Anode for the state the prescaler moves into; a tick always lands in
      // dead time, so the old anode drops on the same edge the new code loads.
      an_d = AN_ALL;
      if (!tick && (pre >= DEAD_M1) && !dark_d)
         an_d = ~(NUM_DIGITS'(1) << idx_d);

      frame_d = tick && (idx_d == '0);
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         idx_q   <= '0;
         fc_q    <= '0;
         bph_q   <= 1'b1;
         init_q  <= 1'b1;
         dark_q  <= 1'b0;
         dig_q   <= 4'h0;
         dp_q    <= DP_OFF;
         an_q    <= AN_ALL;
         frame_q <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         fc_q    <= fc_d;
         bph_q   <= bph_d;
         init_q  <= init_d;
         dark_q  <= dark_d;
         dig_q   <= dig_d;
         dp_q    <= dp_d;
         an_q    <= an_d;
         frame_q <= frame_d;
      end
   end

   assign oDIG   = dig_q;
   assign oAN    = an_q;
   assign oDP    = dp_q;
   assign oFRAME = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with a per-cycle scoreboard of expected outputs.
module tb_seg7_scan;

   localparam int ND = 4;
   localparam int SD = 8;
   localparam int DT = 2;
   localparam int BD = 2;

   logic        iCLK   = 1'b0;
   logic        iRST_N = 1'b1;
   logic [15:0] iDIGITS = 16'h4321;
   logic [3:0]  iBLANK  = 4'b0000;
   logic [3:0]  iBLINK  = 4'b0000;
   logic [3:0]  iDP     = 4'b0000;
   logic [3:0]  oDIG;
   logic [3:0]  oAN;
   logic        oDP;
   logic        oFRAME;

   typedef struct packed {
      logic [3:0] an;
      logic [3:0] dig;
      logic       dp;
      logic       fr;
   } obs_t;

   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n        = 0;
   logic [3:0] s_dig;
   logic       s_blank, s_blink, s_dp;

   seg7_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD(DT), .BLINK_DIV(BD)) dut (
      .iCLK    (iCLK),
      .iRST_N  (iRST_N),
      .iDIGITS (iDIGITS),
      .iBLANK  (iBLANK),
      .iBLINK  (iBLINK),
      .iDP     (iDP),
      .oDIG    (oDIG),
      .oAN     (oAN),
      .oDP     (oDP),
      .oFRAME  (oFRAME)
   );

   always #5 iCLK = ~iCLK;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", n);
      $fatal(1, "watchdog expired");
   end

   // Expected outputs after edge e since reset release, from slot arithmetic.
   function automatic obs_t model(input int e);
      obs_t o;
      int   pre, s, k, f;
      logic bph, dark;
      pre  = e % SD;
      s    = e / SD;
      k    = s % ND;
      f    = s / ND;
      bph  = ((f / BD) % 2) == 0;
      dark = s_blank || (s_blink && !bph);
      o.an  = (pre >= DT && !dark) ? ~(4'b0001 << k) : 4'b1111;
      o.dig = s_dig;
      o.dp  = dark ? 1'b1 : ~s_dp;
      o.fr  = (pre == 0) && (k == 0) && (s > 0);
      return o;
   endfunction

   task automatic check(input string tag, input obs_t got, input obs_t want);
      n_checks++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s cycle %0d: got an=%b dig=%h dp=%b fr=%b, expected an=%b dig=%h dp=%b fr=%b",
                tag, n, got.an, got.dig, got.dp, got.fr, want.an, want.dig, want.dp, want.fr);
      end
   endtask

   task automatic step(input string tag);
      int e;
      int k;
      e = n + 1;
      k = (e / SD) % ND;
      if (e == 1 || e % SD == 0) begin
         s_dig   = iDIGITS[4*k +: 4];
         s_blank = iBLANK[k];
         s_blink = iBLINK[k];
         s_dp    = iDP[k];
      end
      exp_q.push_back(model(e));
      @(posedge iCLK);
      #1;
      n = e;
      check(tag, {oAN, oDIG, oDP, oFRAME}, exp_q.pop_front());
   endtask

   task automatic run(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) step(tag);
   endtask

   initial begin
      obs_t rst_val;
      rst_val = '{an: 4'b1111, dig: 4'h0, dp: 1'b1, fr: 1'b0};

      #1 iRST_N = 1'b0;
      repeat (2) @(posedge iCLK);
      #1;
      check("reset_hold", {oAN, oDIG, oDP, oFRAME}, rst_val);
      @(negedge iCLK);
      iRST_N = 1'b1;
      n = 0;
      check("reset_release", {oAN, oDIG, oDP, oFRAME}, rst_val);

      run("scan", 40);

      iBLANK = 4'b0100;
      run("blank", 32);
      iBLANK = 4'b0000;

      iBLINK = 4'b0001;
      run("blink", 112);
      iBLINK = 4'b0000;

      iDP = 4'b0010;
      run("dp", 32);
      while (n % SD != 3) step("dp_align");
      iDIGITS = 16'h9ABF;
      run("mid_slot_change", 20);
      iDP = 4'b0000;

      while (n % SD != 4) step("pre_reset");
      #2 iRST_N = 1'b0;
      #1;
      check("async_reset", {oAN, oDIG, oDP, oFRAME}, rst_val);
      @(negedge iCLK);
      iRST_N = 1'b1;
      n = 0;
      check("after_reset_release", {oAN, oDIG, oDP, oFRAME}, rst_val);
      run("restart", 40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
